// File: rtl/mrfm_iir_sched_pkg.sv
// Shared constants and types for the MRFM IIR channel scheduler.
// FR_MRFM_IIR_SCHED is the settings-bus address of the scheduler config register.
package mrfm_iir_sched_pkg;

  localparam logic [6:0] FR_MRFM_IIR_SCHED = 7'd52;
  localparam int         SAMPLE_W          = 16;

  typedef logic [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/mrfm_iir_sched_rr_arb.sv
// Combinational round-robin picker: first set request searching upward from last+1,
// wrapping around, so the most recently served channel has lowest priority.
module mrfm_rr_arb
  import mrfm_iir_sched_pkg::*;
#(
  parameter int NCHAN = 4,
  parameter int CW    = 2
) (
  input  logic [NCHAN-1:0] req,
  input  logic [CW-1:0]    last,
  output logic             gnt_valid,
  output logic [CW-1:0]    gnt_idx
);

  logic [CW-1:0] pos;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    pos       = '0;
    for (int i = 1; i <= NCHAN; i++) begin
      pos = CW'((int'(last) + i) % NCHAN);
      if (!gnt_valid && req[pos]) begin
        gnt_valid = 1'b1;
        gnt_idx   = pos;
      end
    end
  end

endmodule

// File: rtl/mrfm_iir_sched.sv
// Time-shares one mrfm_iir engine among NCHAN sample channels: latches samples,
// grants the engine round-robin and returns each result tagged with its channel.
module mrfm_iir_sched
  import mrfm_iir_sched_pkg::*;
#(
  parameter int NCHAN          = 4,
  parameter int CW             = 2,
  parameter int ENGINE_LATENCY = 40
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  serial_strobe,
  input  logic [6:0]            serial_addr,
  input  logic [31:0]           serial_data,
  input  logic [NCHAN-1:0]      in_strobe,
  input  logic [16*NCHAN-1:0]   in_sample,
  output logic                  eng_strobe,
  output logic [15:0]           eng_sample,
  output logic [CW-1:0]         eng_chan,
  input  logic [15:0]           eng_sample_out,
  output logic                  out_strobe,
  output logic [CW-1:0]         out_chan,
  output logic [15:0]           out_sample,
  output logic [NCHAN-1:0]      overrun,
  output logic                  busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  localparam int         CNTW = $clog2(ENGINE_LATENCY + 1);

  logic [0:0]       state;
  logic [CNTW-1:0]  cnt;
  logic [NCHAN-1:0] enable;
  logic [NCHAN-1:0] pending;
  sample_t          hold [NCHAN];
  logic [CW-1:0]    last_grant;
  logic [CW-1:0]    gnt_idx;
  logic             gnt_valid;
  logic             cfg_wr;
  logic             grant;
  logic             unused_cfg_bits;

  assign cfg_wr          = serial_strobe && (serial_addr == FR_MRFM_IIR_SCHED);
  assign grant           = (state == IDLE) && gnt_valid;
  assign busy            = (state == RUN);
  assign unused_cfg_bits = ^serial_data[30:NCHAN];

  mrfm_rr_arb #(.NCHAN(NCHAN), .CW(CW)) u_arb (
    .req       (pending & enable),
    .last      (last_grant),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // A strobe coinciding with its own grant refills the holding register without
  // counting as an overrun, since the old sample leaves for the engine that cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      enable  <= '0;
      pending <= '0;
      overrun <= '0;
      for (int i = 0; i < NCHAN; i++) hold[i] <= '0;
    end else begin
      if (cfg_wr) enable <= serial_data[NCHAN-1:0];
      for (int i = 0; i < NCHAN; i++) begin
        if (!enable[i]) begin
          pending[i] <= 1'b0;
        end else if (in_strobe[i]) begin
          hold[i]    <= in_sample[16*i +: 16];
          pending[i] <= 1'b1;
          if (pending[i] && !(grant && gnt_idx == CW'(i))) overrun[i] <= 1'b1;
        end else if (grant && gnt_idx == CW'(i)) begin
          pending[i] <= 1'b0;
        end
      end
      if (cfg_wr && serial_data[31]) overrun <= '0;
    end
  end

  // cnt is 0 in the eng_strobe cycle, so reaching ENGINE_LATENCY lines the
  // capture up with the edge on which the engine result becomes valid.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= CW'(NCHAN - 1);
      eng_strobe <= 1'b0;
      eng_sample <= '0;
      eng_chan   <= '0;
      out_strobe <= 1'b0;
      out_chan   <= '0;
      out_sample <= '0;
    end else begin
      eng_strobe <= 1'b0;
      out_strobe <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            eng_strobe <= 1'b1;
            eng_sample <= hold[gnt_idx];
            eng_chan   <= gnt_idx;
            last_grant <= gnt_idx;
            cnt        <= '0;
            state      <= RUN;
          end
        end
        RUN: begin
          cnt <= cnt + CNTW'(1);
          if (cnt == CNTW'(ENGINE_LATENCY)) begin
            out_sample <= eng_sample_out;
            out_chan   <= eng_chan;
            out_strobe <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mrfm_iir_sched.sv
// Scoreboard bench for mrfm_iir_sched with a stub engine whose result is only
// valid on the exact cycle the scheduler is supposed to sample it.
module tb_mrfm_iir_sched;
  import mrfm_iir_sched_pkg::*;

  localparam int NCHAN = 4;
  localparam int CW    = 2;
  localparam int EL    = 40;

  typedef struct packed {
    logic [1:0]  chan;
    logic [15:0] val;
  } exp_t;

  logic              clock = 1'b0;
  logic              reset;
  logic              serial_strobe;
  logic [6:0]        serial_addr;
  logic [31:0]       serial_data;
  logic [NCHAN-1:0]  in_strobe;
  logic [16*NCHAN-1:0] in_sample;
  logic              eng_strobe;
  logic [15:0]       eng_sample;
  logic [CW-1:0]     eng_chan;
  logic [15:0]       eng_sample_out;
  logic              out_strobe;
  logic [CW-1:0]     out_chan;
  logic [15:0]       out_sample;
  logic [NCHAN-1:0]  overrun;
  logic              busy;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int eng_cnt    = 0;
  int out_cnt    = 0;
  int last_s     = -1000;
  int scnt       = 1000;
  exp_t gnt_q[$];
  exp_t res_q[$];
  int strobe_cycles[$];

  mrfm_iir_sched #(.NCHAN(NCHAN), .CW(CW), .ENGINE_LATENCY(EL)) dut (
    .clock          (clock),
    .reset          (reset),
    .serial_strobe  (serial_strobe),
    .serial_addr    (serial_addr),
    .serial_data    (serial_data),
    .in_strobe      (in_strobe),
    .in_sample      (in_sample),
    .eng_strobe     (eng_strobe),
    .eng_sample     (eng_sample),
    .eng_chan       (eng_chan),
    .eng_sample_out (eng_sample_out),
    .out_strobe     (out_strobe),
    .out_chan       (out_chan),
    .out_sample     (out_sample),
    .overrun        (overrun),
    .busy           (busy)
  );

  function automatic logic [15:0] stub_fn(input logic [15:0] s, input logic [1:0] c);
    return s ^ 16'hACDB ^ {c, 14'h0};
  endfunction

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (eng_strobe) scnt <= 1;
    else            scnt <= scnt + 1;
  end

  assign eng_sample_out = (scnt == EL) ? stub_fn(eng_sample, eng_chan) : 16'hDEAD;

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clock);
      if (eng_strobe) begin
        eng_cnt++;
        strobe_cycles.push_back(cyc);
        last_s = cyc;
        compared++;
        if (gnt_q.size() == 0) begin
          mismatched++;
          $display("[TB] FAIL grant_unexpected: got chan=%0d sample=%h, expected no grant", eng_chan, eng_sample);
        end else begin
          e = gnt_q.pop_front();
          if ({eng_chan, eng_sample} !== {e.chan, e.val}) begin
            mismatched++;
            $display("[TB] FAIL grant: got chan=%0d sample=%h, expected chan=%0d sample=%h",
                     eng_chan, eng_sample, e.chan, e.val);
          end
        end
      end
      if (out_strobe) begin
        out_cnt++;
        compared++;
        if (cyc !== last_s + EL + 1) begin
          mismatched++;
          $display("[TB] FAIL result_timing: got cycle %0d, expected %0d", cyc, last_s + EL + 1);
        end
        compared++;
        if (res_q.size() == 0) begin
          mismatched++;
          $display("[TB] FAIL result_unexpected: got chan=%0d sample=%h, expected no result", out_chan, out_sample);
        end else begin
          e = res_q.pop_front();
          if ({out_chan, out_sample} !== {e.chan, e.val}) begin
            mismatched++;
            $display("[TB] FAIL result: got chan=%0d sample=%h, expected chan=%0d sample=%h",
                     out_chan, out_sample, e.chan, e.val);
          end
        end
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    step(1);
    reset = 1'b1;
    in_strobe = '0;
    serial_strobe = 1'b0;
    step(2);
    reset = 1'b0;
  endtask

  task automatic cfg_write(input logic [31:0] d);
    serial_strobe = 1'b1;
    serial_addr   = FR_MRFM_IIR_SCHED;
    serial_data   = d;
    step(1);
    serial_strobe = 1'b0;
    serial_data   = '0;
  endtask

  task automatic strobe_ch(input int ch, input logic [15:0] v);
    in_strobe[ch] = 1'b1;
    in_sample[16*ch +: 16] = v;
    step(1);
    in_strobe = '0;
  endtask

  task automatic push_exp(input logic [1:0] ch, input logic [15:0] v);
    gnt_q.push_back({ch, v});
    res_q.push_back({ch, stub_fn(v, ch)});
  endtask

  task automatic wait_drain(input int limit);
    int n;
    n = 0;
    while ((gnt_q.size() != 0 || res_q.size() != 0 || busy) && n < limit) begin
      @(negedge clock);
      n++;
    end
    compared++;
    if (n >= limit) begin
      mismatched++;
      $display("[TB] FAIL drain_timeout: got %0d grants / %0d results outstanding, expected 0",
               gnt_q.size(), res_q.size());
      gnt_q.delete();
      res_q.delete();
    end
    step(1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    compared++; if (eng_strobe !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_eng_strobe: got %b, expected 0", eng_strobe); end
    compared++; if (eng_sample !== 16'h0) begin mismatched++; $display("[TB] FAIL rst_eng_sample: got %h, expected 0", eng_sample); end
    compared++; if (eng_chan !== 2'd0) begin mismatched++; $display("[TB] FAIL rst_eng_chan: got %0d, expected 0", eng_chan); end
    compared++; if (out_strobe !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_out_strobe: got %b, expected 0", out_strobe); end
    compared++; if (out_chan !== 2'd0) begin mismatched++; $display("[TB] FAIL rst_out_chan: got %0d, expected 0", out_chan); end
    compared++; if (out_sample !== 16'h0) begin mismatched++; $display("[TB] FAIL rst_out_sample: got %h, expected 0", out_sample); end
    compared++; if (overrun !== 4'h0) begin mismatched++; $display("[TB] FAIL rst_overrun: got %b, expected 0000", overrun); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_busy: got %b, expected 0", busy); end
    step(1);
    reset = 1'b0;
    step(1);
  endtask

  task automatic test_single();
    do_reset();
    cfg_write(32'h0000_0001);
    gnt_q.push_back({2'd0, 16'h1234});
    res_q.push_back({2'd0, 16'hBEEF});
    strobe_ch(0, 16'h1234);
    step(1);
    @(negedge clock);
    compared++; if (eng_strobe !== 1'b1) begin mismatched++; $display("[TB] FAIL single_strobe_latency: got %b, expected 1", eng_strobe); end
    compared++; if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL single_busy: got %b, expected 1", busy); end
    wait_drain(200);
  endtask

  task automatic test_back_to_back();
    do_reset();
    cfg_write(32'h0000_000F);
    strobe_cycles.delete();
    for (int c = 0; c < 4; c++) push_exp(2'(c), 16'(c + 1));
    in_sample = {16'd4, 16'd3, 16'd2, 16'd1};
    in_strobe = 4'hF;
    step(1);
    in_strobe = '0;
    wait_drain(400);
    compared++;
    if (strobe_cycles.size() !== 4) begin
      mismatched++;
      $display("[TB] FAIL b2b_grant_count: got %0d, expected 4", strobe_cycles.size());
    end else begin
      for (int k = 1; k < 4; k++) begin
        compared++;
        if (strobe_cycles[k] - strobe_cycles[k-1] !== EL + 2) begin
          mismatched++;
          $display("[TB] FAIL b2b_spacing: got %0d, expected %0d", strobe_cycles[k] - strobe_cycles[k-1], EL + 2);
        end
      end
    end
    compared++; if (overrun !== 4'h0) begin mismatched++; $display("[TB] FAIL b2b_overrun: got %b, expected 0000", overrun); end
  endtask

  task automatic test_overrun();
    do_reset();
    cfg_write(32'h0000_0003);
    push_exp(2'd0, 16'h0A00);
    push_exp(2'd1, 16'h2222);
    strobe_ch(0, 16'h0A00);
    strobe_ch(1, 16'h1111);
    step(4);
    strobe_ch(1, 16'h2222);
    @(negedge clock);
    compared++; if (overrun !== 4'b0010) begin mismatched++; $display("[TB] FAIL overrun_set: got %b, expected 0010", overrun); end
    wait_drain(300);
    compared++; if (overrun !== 4'b0010) begin mismatched++; $display("[TB] FAIL overrun_sticky: got %b, expected 0010", overrun); end
    cfg_write(32'h8000_0003);
    @(negedge clock);
    compared++; if (overrun !== 4'b0000) begin mismatched++; $display("[TB] FAIL overrun_clear: got %b, expected 0000", overrun); end
    step(1);
  endtask

  task automatic test_same_cycle_grant();
    do_reset();
    cfg_write(32'h0000_0004);
    push_exp(2'd2, 16'h00AA);
    push_exp(2'd2, 16'h00BB);
    strobe_ch(2, 16'h00AA);
    strobe_ch(2, 16'h00BB);
    wait_drain(300);
    compared++; if (overrun !== 4'h0) begin mismatched++; $display("[TB] FAIL same_cycle_overrun: got %b, expected 0000", overrun); end
  endtask

  task automatic test_reset_mid_run();
    int n;
    int e0;
    int o0;
    do_reset();
    cfg_write(32'h0000_0001);
    gnt_q.push_back({2'd0, 16'h0777});
    strobe_ch(0, 16'h0777);
    n = 0;
    while (!eng_strobe && n < 10) begin
      @(negedge clock);
      n++;
    end
    compared++;
    if (n >= 10) begin
      mismatched++;
      $display("[TB] FAIL midrst_grant_timeout: got no eng_strobe, expected one");
      gnt_q.delete();
    end
    e0 = eng_cnt;
    o0 = out_cnt;
    repeat (20) @(posedge clock);
    #1 reset = 1'b1;
    step(2);
    reset = 1'b0;
    @(negedge clock);
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_busy: got %b, expected 0", busy); end
    compared++; if ({eng_sample, eng_chan, out_sample, out_chan} !== '0) begin
      mismatched++;
      $display("[TB] FAIL midrst_outputs: got eng %h/%0d out %h/%0d, expected all 0", eng_sample, eng_chan, out_sample, out_chan);
    end
    step(1);
    strobe_ch(0, 16'h0999);
    step(EL + 20);
    compared++; if (eng_cnt - e0 !== 0) begin mismatched++; $display("[TB] FAIL midrst_grants: got %0d, expected 0", eng_cnt - e0); end
    compared++; if (out_cnt - o0 !== 0) begin mismatched++; $display("[TB] FAIL midrst_results: got %0d, expected 0", out_cnt - o0); end
  endtask

  task automatic test_disable_pending();
    int e0;
    int o0;
    do_reset();
    cfg_write(32'h0000_0009);
    e0 = eng_cnt;
    o0 = out_cnt;
    push_exp(2'd0, 16'h0100);
    strobe_ch(0, 16'h0100);
    strobe_ch(3, 16'h0300);
    cfg_write(32'h0000_0000);
    wait_drain(200);
    step(EL + 20);
    compared++; if (eng_cnt - e0 !== 1) begin mismatched++; $display("[TB] FAIL disable_grants: got %0d, expected 1", eng_cnt - e0); end
    compared++; if (out_cnt - o0 !== 1) begin mismatched++; $display("[TB] FAIL disable_results: got %0d, expected 1", out_cnt - o0); end
  endtask

  initial begin
    reset         = 1'b1;
    serial_strobe = 1'b0;
    serial_addr   = '0;
    serial_data   = '0;
    in_strobe     = '0;
    in_sample     = '0;
    fork
      monitor();
    join_none
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_same_cycle_grant();
    test_reset_mid_run();
    test_disable_pending();
    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
